alu_issue_stage: RTL and testbench

//  Decode-to-execute pipeline stage directly upstream of the ALU.
//  - Takes a fetched RV32I instruction plus register-file read data.
//  - Decodes it into ALU controls (op, sign, b_negate, b_add_one) and operands a/b.
//  - Registers the result behind a valid/ready handshake with a 2-entry skid buffer,
//    so the ALU input is always a registered, stall-safe bundle.

---
 rtl/alu_issue_stage.sv | 218 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: RV32I decode into ALU controls/operands, registered
// behind a 2-entry skid buffer. Optional macro ALU_ISSUE_ILLEGAL_EN enables illegal flagging.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sign,
  output logic             out_b_negate,
  output logic             out_b_add_one,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_branch,
  output logic [2:0]       out_br_f3,
  output logic [WIDTH-1:0] out_store_data,
  output logic             out_illegal
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             b_negate;
    logic             b_add_one;
    logic [4:0]       rd;
    logic             rd_we;
    logic             branch;
    logic [2:0]       br_f3;
    logic [WIDTH-1:0] store_data;
    logic             illegal;
  } bundle_t;

  logic [6:0]       w_opcode;
  logic [4:0]       w_rd;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [WIDTH-1:0] w_imm_i;
  logic [WIDTH-1:0] w_imm_s;
  logic [WIDTH-1:0] w_imm_u;
  logic             w_rd_we;
  logic             w_push;
  bundle_t          w_dec;

  bundle_t          r_out;
  bundle_t          r_skid;
  logic             r_out_valid;
  logic             r_skid_valid;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_imm_i  = WIDTH'($signed(in_instr[31:20]));
  assign w_imm_s  = WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_u  = WIDTH'($signed({in_instr[31:12], 12'h000}));

  // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    w_dec       = '0;
    w_dec.rd    = w_rd;
    w_dec.br_f3 = w_f3;
    w_rd_we     = 1'b0;
    case (opcode_e'(w_opcode))
      OPC_OP: begin
        w_dec.op = alu_op_e'(w_f3);
        w_dec.a  = in_rs1;
        w_dec.b  = in_rs2;
        w_rd_we  = 1'b1;
        if (w_f7[5] && w_f3 == 3'b000) begin
          w_dec.b_negate  = 1'b1;
          w_dec.b_add_one = 1'b1;
        end
        if (w_f7[5] && w_f3 == 3'b101) w_dec.sign = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
        if (w_f7 != 7'h00 && w_f7 != 7'h20) begin
          w_dec.illegal = 1'b1;
          w_rd_we       = 1'b0;
        end
`endif
      end
      OPC_OP_IMM: begin
        w_dec.op = alu_op_e'(w_f3);
        w_dec.a  = in_rs1;
        w_dec.b  = w_imm_i;
        w_rd_we  = 1'b1;
        if (w_f7[5] && w_f3 == 3'b101) w_dec.sign = 1'b1;
      end
      OPC_LUI: begin
        w_dec.b = w_imm_u;
        w_rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.a = in_pc;
        w_dec.b = w_imm_u;
        w_rd_we = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.a = in_rs1;
        w_dec.b = w_imm_i;
        w_rd_we = 1'b1;
      end
      OPC_STORE: begin
        w_dec.a          = in_rs1;
        w_dec.b          = w_imm_s;
        w_dec.store_data = in_rs2;
      end
      OPC_JAL, OPC_JALR: begin
        w_dec.a = in_pc;
        w_dec.b = WIDTH'(4);
        w_rd_we = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.branch = 1'b1;
        w_dec.a      = in_rs1;
        w_dec.b      = in_rs2;
        case (w_f3[2:1])
          2'b00: begin
            w_dec.b_negate  = 1'b1;
            w_dec.b_add_one = 1'b1;
          end
          2'b10:   w_dec.op = ALU_SLT;
          2'b11:   w_dec.op = ALU_SLTU;
          default: w_dec.op = ALU_ADD;
        endcase
      end
      default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        w_dec.illegal = 1'b1;
`endif
      end
    endcase
    // Register and immediate shifts both take only the low 5 bits as shift amount.
    if ((w_opcode == OPC_OP || w_opcode == OPC_OP_IMM) && !w_dec.illegal &&
        (w_f3 == 3'b001 || w_f3 == 3'b101))
      w_dec.b = {{(WIDTH-5){1'b0}}, w_dec.b[4:0]};
    w_dec.rd_we = w_rd_we && (w_rd != 5'd0);
  end

  // in_ready depends only on skid occupancy, so there is no path from out_ready.
  assign in_ready = ~r_skid_valid;
  assign w_push   = in_valid & ~r_skid_valid;

  // NOTE: the payload registers are reset too, because every out_* must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_push;
        if (w_push) r_out <= w_dec;
      end
    end else if (w_push) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_op         = r_out.op;
  assign out_a          = r_out.a;
  assign out_b          = r_out.b;
  assign out_sign       = r_out.sign;
  assign out_b_negate   = r_out.b_negate;
  assign out_b_add_one  = r_out.b_add_one;
  assign out_rd         = r_out.rd;
  assign out_rd_we      = r_out.rd_we;
  assign out_branch     = r_out.branch;
  assign out_br_f3      = r_out.br_f3;
  assign out_store_data = r_out.store_data;
  assign out_illegal    = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, skid backpressure,
// flush and asynchronous reset. Expected values are hand-derived constants.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc, in_rs1, in_rs2;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_op;
  logic [WIDTH-1:0] out_a, out_b;
  logic             out_sign, out_b_negate, out_b_add_one;
  logic [4:0]       out_rd;
  logic             out_rd_we, out_branch;
  logic [2:0]       out_br_f3;
  logic [WIDTH-1:0] out_store_data;
  logic             out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_a(out_a), .out_b(out_b), .out_sign(out_sign),
    .out_b_negate(out_b_negate), .out_b_add_one(out_b_add_one),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_branch(out_branch),
    .out_br_f3(out_br_f3), .out_store_data(out_store_data), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
  endtask

  // Offer one instruction for a single edge, then deassert valid.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    drive(instr, pc, rs1, rs2);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_rd_we", out_rd_we, 0);
    #5 rst_n = 1'b1;
    step();

    // SUB x3,x1,x2
    send(r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33), 32'h0, 32'd5, 32'd7);
    check("sub_valid", out_valid, 1);
    check("sub_op", out_op, 3'b000);
    check("sub_negate", out_b_negate, 1);
    check("sub_add_one", out_b_add_one, 1);
    check("sub_a", out_a, 5);
    check("sub_b", out_b, 7);
    check("sub_rd", out_rd, 3);
    check("sub_rd_we", out_rd_we, 1);
    check("sub_sign", out_sign, 0);

    // SRA, SLL, SRAI shift-amount masking
    send(r_type(7'h20, 5'd2, 5'd1, 3'b101, 5'd4, 7'h33), 32'h0, 32'h80000000, 32'h00000021);
    check("sra_op", out_op, 3'b101);
    check("sra_sign", out_sign, 1);
    check("sra_b", out_b, 1);
    send(r_type(7'h00, 5'd2, 5'd1, 3'b001, 5'd5, 7'h33), 32'h0, 32'h1, 32'hFFFFFFE4);
    check("sll_op", out_op, 3'b001);
    check("sll_b", out_b, 4);
    check("sll_sign", out_sign, 0);
    send(i_type(12'h41F, 5'd1, 3'b101, 5'd6, 7'h13), 32'h0, 32'h1234, 32'h0);
    check("srai_b", out_b, 31);
    check("srai_sign", out_sign, 1);
    check("srai_op", out_op, 3'b101);

    // BLTU and ADDI to x0
    send({7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'h63}, 32'h0, 32'h1, 32'hFFFFFFFF);
    check("bltu_branch", out_branch, 1);
    check("bltu_f3", out_br_f3, 3'b110);
    check("bltu_op", out_op, 3'b011);
    check("bltu_rd_we", out_rd_we, 0);
    check("bltu_b", out_b, 32'hFFFFFFFF);
    send(i_type(12'd5, 5'd0, 3'b000, 5'd0, 7'h13), 32'h0, 32'h0, 32'h0);
    check("addi_x0_rd_we", out_rd_we, 0);
    check("addi_x0_b", out_b, 5);

    // U-type, jump and store immediates
    send({20'h12345, 5'd7, 7'h37}, 32'h0, 32'hDEAD, 32'h0);
    check("lui_a", out_a, 0);
    check("lui_b", out_b, 32'h12345000);
    send({20'h80000, 5'd2, 7'h17}, 32'h100, 32'h0, 32'h0);
    check("auipc_a", out_a, 32'h100);
    check("auipc_b", out_b, 32'h80000000);
    send({20'h0, 5'd1, 7'h6F}, 32'h40, 32'h0, 32'h0);
    check("jal_a", out_a, 32'h40);
    check("jal_b", out_b, 4);
    check("jal_rd_we", out_rd_we, 1);
    send({7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'h23}, 32'h0, 32'h200, 32'hCAFE);
    check("store_b", out_b, 32'hFFFFFFFC);
    check("store_data", out_store_data, 32'hCAFE);
    check("store_rd_we", out_rd_we, 0);

    // Unknown opcode
    send({20'h0, 5'd9, 7'h7F}, 32'h0, 32'h11, 32'h22);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("unk_illegal", out_illegal, 1);
`else
    check("unk_illegal", out_illegal, 0);
    check("unk_a", out_a, 0);
    check("unk_b", out_b, 0);
`endif
    check("unk_rd_we", out_rd_we, 0);
    check("unk_branch", out_branch, 0);
    step();
    check("drain_valid", out_valid, 0);

    // Backpressure: three pushes with out_ready low, then stream out
    out_ready = 1'b0;
    drive(i_type(12'd1, 5'd1, 3'b000, 5'd1, 7'h13), 32'h0, 32'h0, 32'h0);
    step();
    check("bp_first_b", out_b, 1);
    check("bp_ready_after_1", in_ready, 1);
    drive(i_type(12'd2, 5'd1, 3'b000, 5'd1, 7'h13), 32'h0, 32'h0, 32'h0);
    step();
    check("bp_ready_after_2", in_ready, 0);
    check("bp_hold_b", out_b, 1);
    drive(i_type(12'd3, 5'd1, 3'b000, 5'd1, 7'h13), 32'h0, 32'h0, 32'h0);
    step();
    check("bp_third_blocked", in_ready, 0);
    check("bp_still_first", out_b, 1);
    check("bp_valid_held", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("bp_out2_b", out_b, 2);
    check("bp_out2_valid", out_valid, 1);
    check("bp_ready_again", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_out3_b", out_b, 3);
    check("bp_out3_valid", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);

    // Flush with both entries full, then flush drops an offered input
    out_ready = 1'b0;
    drive(i_type(12'd8, 5'd1, 3'b000, 5'd1, 7'h13), 32'h0, 32'h0, 32'h0);
    step();
    step();
    check("fl_full", in_ready, 0);
    flush = 1'b1;
    step();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    step();
    check("fl_dropped", out_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_stays_empty", out_valid, 0);

    // Asynchronous reset mid-stream
    send(i_type(12'd1, 5'd1, 3'b000, 5'd2, 7'h13), 32'h0, 32'h55, 32'h0);
    check("mr_valid_before", out_valid, 1);
    check("mr_a_before", out_a, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 1);
    check("mr_out_a", out_a, 0);
    #2 rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
